// File: rtl/cdb_arbiter_if.sv
// Producer-side result handshake and registered CDB broadcast bundle for cdb_arbiter.
// master = producers/consumers side, slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_LEN = 4,
  parameter int unsigned XLEN    = 32
);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*TAG_LEN-1:0] req_tag;
  logic [NUM_REQ*XLEN-1:0]    req_value;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       squash;
  logic                       cdb_valid;
  logic [TAG_LEN-1:0]         cdb_tag;
  logic [XLEN-1:0]            cdb_value;
  logic [SRC_W-1:0]           cdb_src;
  logic                       err_tag0;

  modport master (
    output req_valid, req_tag, req_value, squash,
    input  req_ready, cdb_valid, cdb_tag, cdb_value, cdb_src, err_tag0
  );

  modport slave (
    input  req_valid, req_tag, req_value, squash,
    output req_ready, cdb_valid, cdb_tag, cdb_value, cdb_src, err_tag0
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-producer result FIFOs drained round-robin,
// one registered broadcast per cycle, with squash flush and sticky tag-0 error.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TAG_LEN   = 4,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TAG_LEN-1:0] tag_mem_q   [NUM_REQ][BUF_DEPTH];
  logic [XLEN-1:0]    value_mem_q [NUM_REQ][BUF_DEPTH];

  logic [PTR_W-1:0] head_q [NUM_REQ];
  logic [PTR_W-1:0] head_d [NUM_REQ];
  logic [PTR_W-1:0] tail_q [NUM_REQ];
  logic [PTR_W-1:0] tail_d [NUM_REQ];
  logic [CNT_W-1:0] cnt_q  [NUM_REQ];
  logic [CNT_W-1:0] cnt_d  [NUM_REQ];

  logic [SRC_W-1:0]   rr_q, rr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_LEN-1:0] cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]    cdb_value_q, cdb_value_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;
  logic               err_q, err_d;

  logic [TAG_LEN-1:0] tag_in [NUM_REQ];
  logic [NUM_REQ-1:0] ready, accept, enq, deq;
  logic               found;
  logic [SRC_W-1:0]   win;
  int unsigned        idx;

  always_comb begin
    ready  = '0;
    accept = '0;
    enq    = '0;
    deq    = '0;
    found  = 1'b0;
    win    = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      tag_in[i] = bus.req_tag[i*TAG_LEN +: TAG_LEN];
      ready[i]  = (cnt_q[i] < CNT_W'(BUF_DEPTH)) && !reset;
      accept[i] = bus.req_valid[i] && ready[i];
      // Tag 0 completes the handshake but is never stored.
      enq[i]    = accept[i] && (tag_in[i] != '0);
    end

    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (k + 32'(rr_q)) % NUM_REQ;
      if (!found && cnt_q[idx] != '0) begin
        found = 1'b1;
        win   = SRC_W'(idx);
      end
    end

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      deq[i] = found && (win == SRC_W'(i));
      if (bus.squash) begin
        cnt_d[i]  = '0;
        head_d[i] = '0;
        tail_d[i] = '0;
      end else begin
        cnt_d[i]  = cnt_q[i] + CNT_W'(enq[i]) - CNT_W'(deq[i]);
        head_d[i] = deq[i] ? head_q[i] + PTR_W'(1) : head_q[i];
        tail_d[i] = enq[i] ? tail_q[i] + PTR_W'(1) : tail_q[i];
      end
    end

    err_d       = err_q;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (accept[i] && tag_in[i] == '0) err_d = 1'b1;

    cdb_valid_d = found && !bus.squash;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_src_d   = cdb_src_q;
    rr_d        = rr_q;
    if (bus.squash) begin
      rr_d = '0;
    end else if (found) begin
      cdb_tag_d   = tag_mem_q[win][head_q[win]];
      cdb_value_d = value_mem_q[win][head_q[win]];
      cdb_src_d   = win;
      rr_d        = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + SRC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_src_q   <= cdb_src_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!bus.squash && enq[i]) begin
        tag_mem_q[i][tail_q[i]]   <= tag_in[i];
        value_mem_q[i][tail_q[i]] <= bus.req_value[i*XLEN +: XLEN];
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_value = cdb_value_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.err_tag0  = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed broadcast sequences checked
// with immediate assertions after each clock edge.
module tb_cdb_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cdb_arbiter_if #(.NUM_REQ(4), .TAG_LEN(4), .XLEN(32)) bus ();

  cdb_arbiter #(
    .NUM_REQ  (4),
    .TAG_LEN  (4),
    .XLEN     (32),
    .BUF_DEPTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic cdb(input string name, input logic v, input logic [3:0] tag, input logic [1:0] src);
    check({name, "_valid"}, 64'(bus.cdb_valid), 64'(v));
    check({name, "_tag"},   64'(bus.cdb_tag),   64'(tag));
    check({name, "_src"},   64'(bus.cdb_src),   64'(src));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_value = '0;
    bus.squash    = 1'b0;
  endtask

  task automatic push(input int p, input logic [3:0] tag, input logic [31:0] val);
    bus.req_valid[p]       = 1'b1;
    bus.req_tag[p*4 +: 4]  = tag;
    bus.req_value[p*32 +: 32] = val;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    #2;
    check("rst_ready", 64'(bus.req_ready), 64'h0);
    check("rst_err",   64'(bus.err_tag0),  64'h0);
    check("rst_value", 64'(bus.cdb_value), 64'h0);
    cdb("rst", 1'b0, 4'd0, 2'd0);
    #10;
    reset = 1'b0;
    #1;
    check("rel_ready", 64'(bus.req_ready), 64'hF);

    // Single result on producer 1
    push(1, 4'd5, 32'hDEAD_BEEF);
    step();
    idle();
    check("single_nobypass", 64'(bus.cdb_valid), 64'h0);
    step();
    cdb("single", 1'b1, 4'd5, 2'd1);
    check("single_value", 64'(bus.cdb_value), 64'hDEAD_BEEF);
    step();
    cdb("single_hold", 1'b0, 4'd5, 2'd1);

    // Squash to bring rr_ptr back to 0
    bus.squash = 1'b1;
    step();
    idle();

    // Fairness: all four at once
    for (int p = 0; p < 4; p++) push(p, 4'(p + 1), 32'(100 + p));
    step();
    idle();
    for (int p = 0; p < 4; p++) begin
      step();
      cdb("fair", 1'b1, 4'(p + 1), 2'(p));
      check("fair_value", 64'(bus.cdb_value), 64'(100 + p));
    end
    step();
    check("fair_idle", 64'(bus.cdb_valid), 64'h0);
    push(0, 4'd7, 32'h7);
    push(3, 4'd9, 32'h9);
    step();
    idle();
    step();
    cdb("rr_wrap0", 1'b1, 4'd7, 2'd0);
    step();
    cdb("rr_wrap3", 1'b1, 4'd9, 2'd3);
    step();
    check("rr_wrap_idle", 64'(bus.cdb_valid), 64'h0);

    // Backpressure on producer 2 (rr_ptr = 0)
    push(0, 4'd1, 32'h0);
    push(1, 4'd2, 32'h0);
    step();
    idle();
    push(0, 4'd3, 32'h0);
    push(1, 4'd4, 32'h0);
    push(2, 4'd10, 32'h0);
    step();
    cdb("bp_e2", 1'b1, 4'd1, 2'd0);
    idle();
    push(2, 4'd11, 32'h0);
    step();
    cdb("bp_e3", 1'b1, 4'd2, 2'd1);
    check("bp_full", 64'(bus.req_ready[2]), 64'h0);
    idle();
    push(2, 4'd12, 32'h0);
    step();
    cdb("bp_e4", 1'b1, 4'd10, 2'd2);
    check("bp_drained", 64'(bus.req_ready[2]), 64'h1);
    step();
    cdb("bp_e5", 1'b1, 4'd3, 2'd0);
    check("bp_refull", 64'(bus.req_ready[2]), 64'h0);
    idle();
    step();
    cdb("bp_e6", 1'b1, 4'd4, 2'd1);
    step();
    cdb("bp_e7", 1'b1, 4'd11, 2'd2);
    step();
    cdb("bp_e8", 1'b1, 4'd12, 2'd2);
    step();
    check("bp_idle", 64'(bus.cdb_valid), 64'h0);

    // Squash with five buffered results plus one new request (rr_ptr = 3)
    push(0, 4'd1, 32'h0);
    push(1, 4'd2, 32'h0);
    push(2, 4'd3, 32'h0);
    step();
    idle();
    push(0, 4'd5, 32'h0);
    push(1, 4'd6, 32'h0);
    push(2, 4'd7, 32'h0);
    step();
    cdb("sq_pre", 1'b1, 4'd1, 2'd0);
    idle();
    push(3, 4'd9, 32'h0);
    bus.squash = 1'b1;
    step();
    idle();
    check("sq_valid", 64'(bus.cdb_valid), 64'h0);
    check("sq_ready", 64'(bus.req_ready), 64'hF);
    for (int c = 0; c < 3; c++) begin
      step();
      cdb("sq_after", 1'b0, 4'd1, 2'd0);
    end

    // Tag zero
    push(0, 4'd0, 32'h1234);
    #1;
    check("t0_ready", 64'(bus.req_ready[0]), 64'h1);
    step();
    idle();
    check("t0_err", 64'(bus.err_tag0), 64'h1);
    check("t0_nobcast", 64'(bus.cdb_valid), 64'h0);
    step();
    check("t0_nobcast2", 64'(bus.cdb_valid), 64'h0);
    check("t0_ready_after", 64'(bus.req_ready), 64'hF);
    bus.squash = 1'b1;
    step();
    idle();
    check("t0_sticky", 64'(bus.err_tag0), 64'h1);

    // Async reset mid-stream (rr_ptr = 0)
    push(0, 4'd1, 32'h0);
    push(1, 4'd2, 32'h0);
    push(2, 4'd3, 32'h0);
    step();
    idle();
    push(0, 4'd4, 32'h0);
    step();
    idle();
    cdb("ar_pre", 1'b1, 4'd1, 2'd0);
    #2;
    reset = 1'b1;
    #1;
    cdb("ar_async", 1'b0, 4'd0, 2'd0);
    check("ar_ready", 64'(bus.req_ready), 64'h0);
    check("ar_err", 64'(bus.err_tag0), 64'h0);
    #2;
    reset = 1'b0;
    push(0, 4'd6, 32'h0);
    push(3, 4'd7, 32'h0);
    step();
    idle();
    check("ar_nostale", 64'(bus.cdb_valid), 64'h0);
    step();
    cdb("ar_first", 1'b1, 4'd6, 2'd0);
    step();
    cdb("ar_second", 1'b1, 4'd7, 2'd3);
    step();
    check("ar_idle", 64'(bus.cdb_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) among NUM_REQ functional-unit result producers: ALU, multiplier, load unit, branch unit.
Each producer pushes completed results (ROB tag + value) into a small private buffer. A round-robin arbiter drains one buffered result per cycle onto the registered CDB broadcast. Reservation stations and the ROB consume that broadcast.
Provides backpressure to producers and a flush path for mispredict recovery.

Parameters:
NUM_REQ, 4, number of result producers (>=2)
TAG_LEN, 4, ROB tag width; tag 0 is reserved and means "no tag"
XLEN, 32, result value width
BUF_DEPTH, 2, entries per producer buffer (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  producer i has a result this cycle
req_tag  in  NUM_REQ*TAG_LEN  producer i tag at bits [i*TAG_LEN +: TAG_LEN]
req_value  in  NUM_REQ*XLEN  producer i value at bits [i*XLEN +: XLEN]
req_ready  out  NUM_REQ  producer i buffer can accept this cycle
squash  in  1  synchronous flush of all buffered results
cdb_valid  out  1  broadcast valid (registered)
cdb_tag  out  TAG_LEN  broadcast ROB tag (registered)
cdb_value  out  XLEN  broadcast value (registered)
cdb_src  out  $clog2(NUM_REQ)  index of the producer that won the current broadcast
err_tag0  out  1  sticky: a request with tag 0 was presented

Behaviour:
- Reset (async): all buffers empty, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0, err_tag0=0. req_ready=0 while reset is high.
- Per-producer buffer: circular FIFO with head pointer, tail pointer and count of $clog2(BUF_DEPTH)+1 bits.
- req_ready[i] = (count_i < BUF_DEPTH) & ~reset. This is purely combinational from state. It does not depend on same-cycle grant, so a full buffer is not refilled in the cycle it is drained.
- Enqueue when req_valid[i] & req_ready[i] at posedge. req_valid while not ready is ignored; the producer must hold its result.
- Tag 0 request: accepted (handshake completes), not stored, err_tag0 set to 1 until reset.
- Arbitration (combinational, every cycle): the candidate set is the producers with count>0. Winner = first candidate found scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- On a grant to winner w: at posedge, cdb_valid<=1, cdb_tag/cdb_value<=head of buffer w, cdb_src<=w. Pop buffer w. rr_ptr<=(w+1) mod NUM_REQ.
- No candidate: cdb_valid<=0. cdb_tag, cdb_value and cdb_src hold their last values. rr_ptr unchanged.
- Latency: a result enqueued at edge N into an empty, winning buffer is on the CDB after edge N+1, i.e. the minimum is 1 cycle of buffering. There is no bypass.
- Simultaneous enqueue and dequeue on the same buffer in one cycle (count<BUF_DEPTH): both happen, count unchanged.
- Throughput: exactly one broadcast per cycle while any buffer is non-empty. Every producer is starved for at most NUM_REQ-1 grants.
- squash=1 at posedge: all counts and pointers go to 0, and requests handshaken in that cycle are discarded. cdb_valid<=0, rr_ptr<=0. err_tag0 is unaffected. squash has priority over enqueue and grant.
- Reset asserted mid-operation: immediate return to the reset state. Buffered results are lost.
- Pointer wrap: head and tail wrap modulo BUF_DEPTH. rr_ptr wraps modulo NUM_REQ, including non-power-of-two NUM_REQ.

Test Plan:
- Single result: req_valid[1]=1, tag=5, value=0xDEAD_BEEF for one cycle -> next cycle cdb_valid=1, cdb_tag=5, cdb_value=0xDEADBEEF, cdb_src=1. The cycle after, cdb_valid=0.
- Fairness: all 4 producers present one result in the same cycle (tags 1..4), rr_ptr=0 -> CDB emits tags 1,2,3,4 on 4 consecutive cycles with cdb_src 0,1,2,3. rr_ptr ends at 0.
- Backpressure: producer 2 pushes 3 results on consecutive cycles while producers 0 and 1 keep their buffers non-empty -> req_ready[2]=0 once 2 entries are buffered. The third result is accepted only after a grant to producer 2. No result is lost or duplicated; per-producer order is preserved.
- Squash: buffers hold 5 results total and squash is pulsed together with a new req_valid[3] -> next cycle cdb_valid=0 and all req_ready=1. None of the 6 tags ever appears on the CDB.
- Tag zero: req_valid[0]=1, tag=0 -> req_ready[0]=1, err_tag0=1 from the next cycle, and no CDB broadcast. err_tag0 stays 1 through a squash and clears only on reset.
- Async reset mid-stream: assert reset between clock edges while 3 results are buffered -> cdb_valid and req_ready drop to 0 immediately. After release, the first grant is from rr_ptr=0 and no stale tags appear.
